// File: rtl/fir_pkg.sv
// Shared definitions for the FIR chain: sample width and the defaults
// used by the decimating averager and its output buffer.
package fir_pkg;
  localparam int FIR_DW       = 8;
  localparam int DEF_LOG2_DEC = 2;
  localparam int DEF_AW       = 3;

  typedef logic [FIR_DW-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever the
// FIFO is non-empty and reads 0 when empty.
module fir_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty & ~clear;
  // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push & ~clear & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/fir_dec_avg_buf.sv
// Averages each block of 2**LOG2_DEC valid FIR samples (truncating) and
// buffers the averages in a show-ahead FIFO drained through valid/ready.
module fir_dec_avg_buf
  import fir_pkg::*;
#(
  parameter int DW       = FIR_DW,
  parameter int LOG2_DEC = DEF_LOG2_DEC,
  parameter int AW       = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   out_count,
  output logic          overflow
);
  localparam int SW = DW + LOG2_DEC;

  logic [LOG2_DEC-1:0] phase;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       sum;
  logic [DW-1:0]       avg;
  logic                block_end;
  logic                push;
  logic                pop;
  logic                empty;
  logic                full;

  // Handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~clear;

  assign block_end = in_valid & (&phase) & ~clear;
  assign sum       = acc + {{LOG2_DEC{1'b0}}, in_data};
  assign avg       = sum[SW-1:LOG2_DEC];
  assign push      = block_end & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      phase    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        phase <= phase + LOG2_DEC'(1);
        acc   <= (phase == '0) ? {{LOG2_DEC{1'b0}}, in_data} : sum;
      end
      if (block_end && full && !pop) overflow <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .DW(DW),
    .AW(AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (avg),
    .dout  (out_data),
    .empty (empty),
    .full  (full),
    .count (out_count)
  );
endmodule
